// File: rtl/i2c_cmd_ctrl_pkg.sv
// i2c_cmd_pkg: shared types and constants for the I2C command sequencer.
// Holds the FSM encoding, command codes, status bit positions and bank sizes.
package i2c_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC
    } state_t;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_CLR_ERR  = 8'h02;
    localparam logic [7:0] CMD_SOFT_RST = 8'h03;

    localparam int STAT_OK       = 0;
    localparam int STAT_CHK_ERR  = 1;
    localparam int STAT_BAD_CMD  = 2;
    localparam int STAT_BAD_ADDR = 3;
    localparam int STAT_TIMEOUT  = 4;
    localparam int STAT_CNT_LSB  = 5;

    localparam int NUM_REGS = 8;
    localparam int TX_BYTES = 11;

    // Error counter saturates at 7.
    function automatic logic [2:0] sat_inc3(input logic [2:0] c);
        return (c == 3'd7) ? c : c + 3'd1;
    endfunction

endpackage

// File: rtl/i2c_cmd_ctrl.sv
// i2c_cmd_ctrl: parses SYNC,CMD,ADDR,DATA,CHK frames from the I2C slave and
// executes them on an 8x8 register bank, keeping an 88-bit readback image.
// Ports: clk, rstn_in (async low), rx_done/rx_data (slave byte stream),
// reg_out (bank), tx_data_buf (readback), cmd_done (pulse), err_flag (level).
// Optional inter-byte timeout: define I2C_CMD_CTRL_TIMEOUT_EN.
module i2c_cmd_ctrl
    import i2c_cmd_pkg::*;
#(
    parameter logic [7:0]            SYNC_BYTE   = 8'h5A,
    parameter int unsigned           TIMEOUT_CYC = 500000,
    parameter logic [8*NUM_REGS-1:0] REG_RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rstn_in,
    input  logic                    rx_done,
    input  logic [7:0]              rx_data,
    output logic [8*NUM_REGS-1:0]   reg_out,
    output logic [8*TX_BYTES-1:0]   tx_data_buf,
    output logic                    cmd_done,
    output logic                    err_flag
);

    state_t state_q, state_d;

    logic [7:0] cmd_q, addr_q, data_q, chk_q;
    logic [7:0] status_q, last_cmd_q, frame_cnt_q;
    logic [2:0] err_cnt_q;

    logic [8*NUM_REGS-1:0] regs_d;
    logic [7:0] st_d, fc_d, last_d;
    logic [2:0] cnt_d;
    logic       err_d;

    logic exec, timeout, in_frame;
    logic f_chk, f_bad_cmd, f_bad_addr, f_err;

    assign exec     = (state_q == ST_EXEC);
    assign in_frame = (state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK});

`ifdef I2C_CMD_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt_q;

    // Fires on the cycle the idle gap inside a frame reaches TIMEOUT_CYC.
    assign timeout = in_frame && !rx_done &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in)
            to_cnt_q <= '0;
        else if (!in_frame || rx_done || timeout)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYC == 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rx_done && rx_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD:  if (rx_done) state_d = ST_ADDR;
            ST_ADDR: if (rx_done) state_d = ST_DATA;
            ST_DATA: if (rx_done) state_d = ST_CHK;
            ST_CHK:  if (rx_done) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            chk_q  <= '0;
        end else if (rx_done) begin
            if (state_q == ST_CMD)  cmd_q  <= rx_data;
            if (state_q == ST_ADDR) addr_q <= rx_data;
            if (state_q == ST_DATA) data_q <= rx_data;
            if (state_q == ST_CHK)  chk_q  <= rx_data;
        end
    end

    // Frame checks; checksum errors mask the command/address checks.
    assign f_chk      = (cmd_q ^ addr_q ^ data_q) != chk_q;
    assign f_bad_cmd  = !f_chk &&
        !(cmd_q inside {CMD_WRITE, CMD_CLR_ERR, CMD_SOFT_RST});
    assign f_bad_addr = !f_chk && (cmd_q == CMD_WRITE) &&
        (addr_q >= 8'(NUM_REGS));
    assign f_err      = f_chk || f_bad_cmd || f_bad_addr;

    always_comb begin
        regs_d = reg_out;
        cnt_d  = err_cnt_q;
        fc_d   = frame_cnt_q;
        last_d = last_cmd_q;
        st_d   = status_q;
        err_d  = err_flag;
        if (exec) begin
            last_d = cmd_q;
            err_d  = f_err;
            if (f_err) begin
                cnt_d = sat_inc3(err_cnt_q);
            end else begin
                fc_d = frame_cnt_q + 8'd1;
                unique case (cmd_q)
                    CMD_WRITE:    regs_d[8*addr_q[2:0] +: 8] = data_q;
                    CMD_CLR_ERR:  cnt_d = 3'd0;
                    CMD_SOFT_RST: regs_d = REG_RST_VAL;
                    default:      regs_d = reg_out;
                endcase
            end
            st_d = '0;
            st_d[STAT_OK]       = !f_err;
            st_d[STAT_CHK_ERR]  = f_chk;
            st_d[STAT_BAD_CMD]  = f_bad_cmd;
            st_d[STAT_BAD_ADDR] = f_bad_addr;
            st_d[7:STAT_CNT_LSB] = cnt_d;
        end else if (timeout) begin
            cnt_d = sat_inc3(err_cnt_q);
            err_d = 1'b1;
            st_d  = '0;
            st_d[STAT_TIMEOUT]   = 1'b1;
            st_d[7:STAT_CNT_LSB] = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            reg_out     <= REG_RST_VAL;
            status_q    <= '0;
            last_cmd_q  <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_flag    <= 1'b0;
            cmd_done    <= 1'b0;
            tx_data_buf <= {REG_RST_VAL, 24'h0};
        end else begin
            cmd_done <= exec || timeout;
            // Image only moves at frame end so the slave sees stable bytes.
            if (exec || timeout) begin
                reg_out     <= regs_d;
                status_q    <= st_d;
                last_cmd_q  <= last_d;
                frame_cnt_q <= fc_d;
                err_cnt_q   <= cnt_d;
                err_flag    <= err_d;
                tx_data_buf <= {regs_d, fc_d, last_d, st_d};
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
// tb_i2c_cmd_ctrl: self-checking bench for i2c_cmd_ctrl with a frame-level
// reference model; timeout checks follow I2C_CMD_CTRL_TIMEOUT_EN.
module tb_i2c_cmd_ctrl;

    localparam int TO = 100;

    logic        clk;
    logic        rstn_in;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [63:0] reg_out;
    logic [87:0] tx_data_buf;
    logic        cmd_done;
    logic        err_flag;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    // Reference model state
    logic [7:0] m_regs [8];
    logic [2:0] m_cnt;
    logic [7:0] m_fc, m_last, m_stat;
    logic       m_err;

    i2c_cmd_ctrl #(
        .SYNC_BYTE(8'h5A),
        .TIMEOUT_CYC(TO),
        .REG_RST_VAL(64'h0)
    ) dut (
        .clk(clk),
        .rstn_in(rstn_in),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .reg_out(reg_out),
        .tx_data_buf(tx_data_buf),
        .cmd_done(cmd_done),
        .err_flag(err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic logic [63:0] m_bank();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    function automatic logic [87:0] m_tx();
        return {m_bank(), m_fc, m_last, m_stat};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_cnt = 0; m_fc = 0; m_last = 0; m_stat = 0; m_err = 0;
    endtask

    task automatic m_frame(input logic [7:0] c, a, d, k);
        bit chk, bc, ba;
        chk = ((c ^ a ^ d) != k);
        bc  = !chk && !(c == 8'h01 || c == 8'h02 || c == 8'h03);
        ba  = !chk && c == 8'h01 && a > 8'd7;
        m_last = c;
        m_err  = chk || bc || ba;
        if (m_err) begin
            if (m_cnt != 7) m_cnt = m_cnt + 1;
        end else begin
            m_fc = m_fc + 1;
            if (c == 8'h01) m_regs[a] = d;
            if (c == 8'h02) m_cnt = 0;
            if (c == 8'h03) for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        end
        m_stat = {m_cnt, 1'b0, ba, bc, chk, !m_err};
    endtask

    task automatic m_timeout();
        if (m_cnt != 7) m_cnt = m_cnt + 1;
        m_err  = 1;
        m_stat = {m_cnt, 5'b10000};
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, a, d, k);
        send_byte(8'h5A);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
        m_frame(c, a, d, k);
    endtask

    task automatic test_reset();
        rstn_in = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        #1 rstn_in = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rstn_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (reg_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_reg got=%h exp=%h", reg_out, 64'h0);
        end
        checks++;
        if (tx_data_buf !== m_tx()) begin
            errors++;
            $display("FAIL reset_tx got=%h exp=%h", tx_data_buf, m_tx());
        end
        checks++;
        if (cmd_done !== 1'b0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b%b exp=00", cmd_done, err_flag);
        end
    endtask

    task automatic test_write();
        int d0;
        d0 = done_cnt;
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'hC3);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'hC1;
        @(negedge clk);
        rx_done = 1'b0;
        checks++;
        if (cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_k got=%b exp=0", cmd_done);
        end
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b1) begin
            errors++;
            $display("FAIL write_done_k1 got=%b exp=1", cmd_done);
        end
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_k2 got=%b exp=0", cmd_done);
        end
        m_frame(8'h01, 8'h03, 8'hC3, 8'hC1);
        checks++;
        if (reg_out[31:24] !== 8'hC3 || tx_data_buf[7:0] !== 8'h01) begin
            errors++;
            $display("FAIL write_reg3 got=%h/%h exp=c3/01",
                     reg_out[31:24], tx_data_buf[7:0]);
        end
        checks++;
        if (tx_data_buf[23:8] !== 16'h0101 || tx_data_buf[55:48] !== 8'hC3) begin
            errors++;
            $display("FAIL write_tx got=%h exp=fc/cmd 0101 reg3 c3", tx_data_buf);
        end
        checks++;
        if ({reg_out, tx_data_buf, err_flag} !== {m_bank(), m_tx(), m_err}) begin
            errors++;
            $display("FAIL write_model got=%h %h %b exp=%h %h %b",
                     reg_out, tx_data_buf, err_flag, m_bank(), m_tx(), m_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL write_pulses got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_chk_err();
        send_frame(8'h01, 8'h02, 8'h11, 8'h00);
        checks++;
        if (tx_data_buf[7:0] !== 8'h22 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL chk_status got=%h/%b exp=22/1", tx_data_buf[7:0], err_flag);
        end
        checks++;
        if ({reg_out, tx_data_buf} !== {m_bank(), m_tx()}) begin
            errors++;
            $display("FAIL chk_model got=%h %h exp=%h %h",
                     reg_out, tx_data_buf, m_bank(), m_tx());
        end
    endtask

    task automatic test_bad_cmd_addr();
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        checks++;
        if (tx_data_buf[7:0] !== 8'h44) begin
            errors++;
            $display("FAIL badcmd_status got=%h exp=44", tx_data_buf[7:0]);
        end
        send_frame(8'h01, 8'h09, 8'hAA, 8'hA2);
        checks++;
        if (tx_data_buf[7:0] !== 8'h68 || reg_out !== m_bank()) begin
            errors++;
            $display("FAIL badaddr_status got=%h exp=68", tx_data_buf[7:0]);
        end
        send_frame(8'h02, 8'h00, 8'h00, 8'h02);
        checks++;
        if (tx_data_buf[7:0] !== 8'h01 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL clrerr_status got=%h/%b exp=01/0", tx_data_buf[7:0], err_flag);
        end
        checks++;
        if (tx_data_buf !== m_tx()) begin
            errors++;
            $display("FAIL clrerr_model got=%h exp=%h", tx_data_buf, m_tx());
        end
    endtask

    task automatic test_garbage();
        int d0;
        d0 = done_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL garbage_done got=%0d exp=0", done_cnt - d0);
        end
        send_frame(8'h01, 8'h00, 8'h55, 8'h54);
        checks++;
        if (reg_out[7:0] !== 8'h55 || tx_data_buf !== m_tx()) begin
            errors++;
            $display("FAIL garbage_write got=%h exp=%h", tx_data_buf, m_tx());
        end
    endtask

    task automatic test_timeout();
        int d0, i;
        d0 = done_cnt;
        send_byte(8'h5A);
        send_byte(8'h01);
`ifdef I2C_CMD_CTRL_TIMEOUT_EN
        i = 0;
        while (i < 3 * TO && done_cnt == d0) begin
            @(negedge clk);
            i++;
        end
        m_timeout();
        checks++;
        if (done_cnt == d0 || i < TO - 10 || i > TO + 5) begin
            errors++;
            $display("FAIL timeout_latency got=%0d cycles exp=~%0d", i, TO);
        end
        checks++;
        if (tx_data_buf !== m_tx() || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_status got=%h/%b exp=%h/1",
                     tx_data_buf, err_flag, m_tx());
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL timeout_pulses got=%0d exp=1", done_cnt - d0);
        end
        send_frame(8'h01, 8'h06, 8'h3C, 8'h3B);
`else
        i = 0;
        repeat (2 * TO) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL notimeout_done got=%0d exp=0", done_cnt - d0);
        end
        send_byte(8'h06);
        send_byte(8'h3C);
        send_byte(8'h3B);
        m_frame(8'h01, 8'h06, 8'h3C, 8'h3B);
`endif
        checks++;
        if ({reg_out, tx_data_buf, err_flag} !== {m_bank(), m_tx(), m_err}) begin
            errors++;
            $display("FAIL after_timeout got=%h %b exp=%h %b",
                     tx_data_buf, err_flag, m_tx(), m_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] c, a, d, k;
        int d0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: c = 8'h01;
                3: c = 8'h02;
                4: c = 8'h03;
                default: c = 8'($urandom);
            endcase
            a = 8'($urandom_range(0, 11));
            d = 8'($urandom);
            k = c ^ a ^ d;
            if ($urandom_range(0, 4) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) send_byte(8'h5A ^ 8'($urandom_range(1, 255)));
            d0 = done_cnt;
            send_frame(c, a, d, k);
            checks++;
            if ({reg_out, tx_data_buf, err_flag} !== {m_bank(), m_tx(), m_err}
                || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL random_%0d frame=%h%h%h%h got=%h %b exp=%h %b",
                         n, c, a, d, k, tx_data_buf, err_flag, m_tx(), m_err);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h04);
        #2 rstn_in = 1'b0;
        m_reset();
        #1;
        checks++;
        if (reg_out !== 64'h0 || tx_data_buf !== 88'h0) begin
            errors++;
            $display("FAIL midrst_async got=%h %h exp=0", reg_out, tx_data_buf);
        end
        repeat (2) @(negedge clk);
        rstn_in = 1'b1;
        d0 = done_cnt;
        send_byte(8'h77);
        send_byte(8'h72);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || tx_data_buf !== 88'h0 || reg_out !== 64'h0) begin
            errors++;
            $display("FAIL midrst_trailing got=%0d %h exp=0 0",
                     done_cnt - d0, tx_data_buf);
        end
        send_frame(8'h01, 8'h07, 8'h9E, 8'h98);
        checks++;
        if ({reg_out, tx_data_buf} !== {m_bank(), m_tx()}) begin
            errors++;
            $display("FAIL midrst_next got=%h exp=%h", tx_data_buf, m_tx());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_chk_err();
        test_bad_cmd_addr();
        test_garbage();
        test_timeout();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
